// File: rtl/game_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_ctrl_if
//   Host / player / display signal bundle for the quiz-buzzer game
//   controller.
//
//   master modport : host side (drives start, judge pulses, buzzes and
//                    player count; observes view, scores, answerer,
//                    winner and countdown).
//   slave modport  : game_ctrl side (the mirror image).
//
//   start         1  one-cycle debounced start pulse
//   judge_ok      1  host "correct answer" pulse
//   judge_bad     1  host "wrong answer" pulse
//   player_btn    4  buzz pulses, bit i = player i+1
//   player_count  3  number of players, sampled on start
//   view          3  0 setup, 1 playing, 2 win
//   playerN_score 7  scores 0..99
//   answerer      3  0 none, 1..4 player holding the floor
//   winner        3  0 none, 1..4
//   countdown     4  seconds left in the answer window
// ---------------------------------------------------------------------------
interface game_ctrl_if;
  logic       start;
  logic       judge_ok;
  logic       judge_bad;
  logic [3:0] player_btn;
  logic [2:0] player_count;

  logic [2:0] view;
  logic [6:0] player1_score;
  logic [6:0] player2_score;
  logic [6:0] player3_score;
  logic [6:0] player4_score;
  logic [2:0] answerer;
  logic [2:0] winner;
  logic [3:0] countdown;

  modport master (
    output start, judge_ok, judge_bad, player_btn, player_count,
    input  view, player1_score, player2_score, player3_score, player4_score,
    input  answerer, winner, countdown
  );

  modport slave (
    input  start, judge_ok, judge_bad, player_btn, player_count,
    output view, player1_score, player2_score, player3_score, player4_score,
    output answerer, winner, countdown
  );
endinterface

// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl
//   Game-flow controller and buzz-in arbiter. Sequences setup / playing /
//   win views, grants the floor to one player with rotating priority, times
//   the answer window in whole seconds and keeps the four scores.
//
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : game_ctrl_if.slave (host pulses, buzzes, display outputs)
//
//   All outputs are registered.
// ---------------------------------------------------------------------------
module game_ctrl #(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int ANSWER_SEC  = 10,
  parameter int CORRECT_PTS = 2,
  parameter int WRONG_PTS   = 1,
  parameter int WIN_SCORE   = 10
) (
  input  logic         clk,
  input  logic         rst,
  game_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READY,
    S_ANSWER,
    S_WIN
  } state_e;

  localparam int            TW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_CYCLES - 1);
  localparam logic [3:0]    ANSWER_LOAD = 4'(ANSWER_SEC);
  localparam logic [7:0]    CORRECT_8   = 8'(CORRECT_PTS);
  localparam logic [7:0]    WRONG_8     = 8'(WRONG_PTS);
  localparam logic [7:0]    WIN_8       = 8'(WIN_SCORE);
  localparam logic [7:0]    MAX_8       = 8'd99;

  state_e          state_q, state_d;
  logic [2:0]      count_q, count_d;       // active players, 2..4
  logic [1:0]      ptr_q, ptr_d;           // 0-based index of last granted player
  logic [TW-1:0]   tick_q, tick_d;
  logic [3:0]      countdown_q, countdown_d;
  logic [2:0]      answerer_q, answerer_d;
  logic [2:0]      winner_q, winner_d;
  logic [2:0]      view_q, view_d;
  logic [6:0]      score_q [4];
  logic [6:0]      score_d [4];

  // ------------------------------------------------------------------------
  // Rotating-priority grant among active players
  // ------------------------------------------------------------------------
  logic [3:0] active_mask;
  logic [3:0] req;
  logic       grant_vld;
  logic [1:0] grant_idx;
  int         idx;

  always_comb begin
    case (count_q)
      3'd2:    active_mask = 4'b0011;
      3'd3:    active_mask = 4'b0111;
      default: active_mask = 4'b1111;
    endcase
    req = bus.player_btn & active_mask;
  end

  // Search starts just after the last granted player and wraps modulo the
  // active count. ptr_q < count_q always holds once a game has started, so a
  // single conditional subtraction implements the wrap.
  always_comb begin
    // NOTE: every variable written here gets a default first; otherwise a
    // path that skips an assignment would infer a latch.
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    idx       = 0;
    for (int k = 1; k <= 4; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= int'(count_q)) idx = idx - int'(count_q);
      if (!grant_vld && (k <= int'(count_q)) && req[idx[1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idx[1:0];
      end
    end
  end

  // ------------------------------------------------------------------------
  // Scoring helpers (8-bit intermediates so saturation never wraps)
  // ------------------------------------------------------------------------
  logic [1:0] ans_idx;
  logic [7:0] cur_score;
  logic [7:0] up_raw;
  logic [7:0] up_sat;
  logic [7:0] dn_sat;
  logic       tick_wrap;
  logic       judge_ok_only;
  logic       judge_bad_only;

  always_comb begin
    ans_idx        = 2'(answerer_q - 3'd1);
    cur_score      = {1'b0, score_q[ans_idx]};
    up_raw         = cur_score + CORRECT_8;
    up_sat         = (up_raw > MAX_8) ? MAX_8 : up_raw;
    dn_sat         = (cur_score < WRONG_8) ? 8'd0 : (cur_score - WRONG_8);
    tick_wrap      = (tick_q == TICK_LAST);
    judge_ok_only  = bus.judge_ok  & ~bus.judge_bad;
    judge_bad_only = bus.judge_bad & ~bus.judge_ok;
  end

  // ------------------------------------------------------------------------
  // Next-state / output logic
  // ------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    tick_d      = tick_q;
    countdown_d = countdown_q;
    answerer_d  = answerer_q;
    winner_d    = winner_q;
    score_d     = score_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < 4; i++) score_d[i] = '0;
          winner_d = 3'd0;
          if (bus.player_count < 3'd2)      count_d = 3'd2;
          else if (bus.player_count > 3'd4) count_d = 3'd4;
          else                              count_d = bus.player_count;
          ptr_d   = 2'(count_d - 3'd1);
          state_d = S_READY;
        end
      end

      S_READY: begin
        if (grant_vld) begin
          answerer_d  = {1'b0, grant_idx} + 3'd1;
          ptr_d       = grant_idx;
          countdown_d = ANSWER_LOAD;
          tick_d      = '0;
          state_d     = S_ANSWER;
        end
      end

      S_ANSWER: begin
        tick_d = tick_wrap ? '0 : tick_q + 1'b1;
        if (tick_wrap) countdown_d = countdown_q - 4'd1;

        // A single judge pulse wins over a simultaneous expiry; a double
        // pulse counts as no judge at all.
        if (judge_ok_only) begin
          score_d[ans_idx] = up_sat[6:0];
          if (up_sat >= WIN_8) begin
            winner_d = answerer_q;
            state_d  = S_WIN;
          end else begin
            state_d  = S_READY;
          end
          answerer_d  = 3'd0;
          countdown_d = 4'd0;
        end else if (judge_bad_only || (tick_wrap && countdown_q == 4'd1)) begin
          score_d[ans_idx] = dn_sat[6:0];
          state_d          = S_READY;
          answerer_d       = 3'd0;
          countdown_d      = 4'd0;
        end
      end

      S_WIN: begin
        if (bus.start) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_IDLE:  view_d = 3'd0;
      S_WIN:   view_d = 3'd2;
      default: view_d = 3'd1;
    endcase
  end

  // ------------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= 3'd4;
      ptr_q       <= 2'd3;
      tick_q      <= '0;
      countdown_q <= 4'd0;
      answerer_q  <= 3'd0;
      winner_q    <= 3'd0;
      view_q      <= 3'd0;
      // NOTE: the score array is four discrete registers, not a RAM, so it
      // is reset element by element like any other flop.
      for (int i = 0; i < 4; i++) score_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      tick_q      <= tick_d;
      countdown_q <= countdown_d;
      answerer_q  <= answerer_d;
      winner_q    <= winner_d;
      view_q      <= view_d;
      score_q     <= score_d;
    end
  end

  assign bus.view          = view_q;
  assign bus.player1_score = score_q[0];
  assign bus.player2_score = score_q[1];
  assign bus.player3_score = score_q[2];
  assign bus.player4_score = score_q[3];
  assign bus.answerer      = answerer_q;
  assign bus.winner        = winner_q;
  assign bus.countdown     = countdown_q;

endmodule

// File: tb/tb_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_ctrl
//   Self-checking bench for game_ctrl. A behavioural model tracks the game
//   in terms of modes, elapsed answer cycles and plain integer scores; every
//   output is compared after every clock edge, with extra directed checks
//   at the scenario points of interest. Ends with a random game section.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_game_ctrl;

  localparam int TICK   = 10;
  localparam int ASEC   = 3;
  localparam int CPTS   = 2;
  localparam int WPTS   = 1;
  localparam int WINS   = 4;

  logic clk;
  logic rst;
  game_ctrl_if bus();

  game_ctrl #(
    .TICK_CYCLES (TICK),
    .ANSWER_SEC  (ASEC),
    .CORRECT_PTS (CPTS),
    .WRONG_PTS   (WPTS),
    .WIN_SCORE   (WINS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Behavioural model
  // mode: 0 setup, 1 waiting for buzz, 2 someone answering, 3 game won
  // ------------------------------------------------------------------------
  int m_mode;
  int m_scores [4];
  int m_players;
  int m_last;      // 1-based player last granted
  int m_holder;    // 1-based answering player, 0 none
  int m_winner;
  int m_elapsed;   // clock edges since the floor was granted

  task automatic model_reset();
    m_mode    = 0;
    for (int i = 0; i < 4; i++) m_scores[i] = 0;
    m_players = 4;
    m_last    = 4;
    m_holder  = 0;
    m_winner  = 0;
    m_elapsed = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit ok, input bit bad,
                            input int btn, input int cnt);
    if (r) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: if (s) begin
        for (int i = 0; i < 4; i++) m_scores[i] = 0;
        m_winner  = 0;
        m_players = (cnt < 2) ? 2 : (cnt > 4) ? 4 : cnt;
        m_last    = m_players;
        m_mode    = 1;
      end
      1: begin
        for (int k = 1; k <= m_players; k++) begin
          int p;
          p = ((m_last - 1 + k) % m_players) + 1;
          if ((btn >> (p - 1)) & 1) begin
            m_holder  = p;
            m_last    = p;
            m_elapsed = 0;
            m_mode    = 2;
            break;
          end
        end
      end
      2: begin
        int s_now;
        m_elapsed++;
        s_now = m_scores[m_holder - 1];
        if (ok && !bad) begin
          s_now = (s_now + CPTS > 99) ? 99 : s_now + CPTS;
          m_scores[m_holder - 1] = s_now;
          if (s_now >= WINS) begin
            m_winner = m_holder;
            m_mode   = 3;
          end else begin
            m_mode = 1;
          end
          m_holder = 0;
        end else if ((bad && !ok) || m_elapsed == ASEC * TICK) begin
          m_scores[m_holder - 1] = (s_now < WPTS) ? 0 : s_now - WPTS;
          m_mode   = 1;
          m_holder = 0;
        end
      end
      default: if (s) m_mode = 0;
    endcase
  endtask

  task automatic compare_all();
    int exp_view, exp_cd;
    exp_view = (m_mode == 0) ? 0 : (m_mode == 3) ? 2 : 1;
    exp_cd   = (m_mode == 2) ? ASEC - m_elapsed / TICK : 0;
    check("view",      int'(bus.view),          exp_view);
    check("answerer",  int'(bus.answerer),      m_holder);
    check("winner",    int'(bus.winner),        m_winner);
    check("countdown", int'(bus.countdown),     exp_cd);
    check("score1",    int'(bus.player1_score), m_scores[0]);
    check("score2",    int'(bus.player2_score), m_scores[1]);
    check("score3",    int'(bus.player3_score), m_scores[2]);
    check("score4",    int'(bus.player4_score), m_scores[3]);
  endtask

  // One clock: drive inputs, step the model at the edge, compare 1ns later.
  task automatic cycle(input bit r, input bit s, input bit ok, input bit bad,
                       input logic [3:0] btn, input logic [2:0] cnt);
    rst              = r;
    bus.start        = s;
    bus.judge_ok     = ok;
    bus.judge_bad    = bad;
    bus.player_btn   = btn;
    bus.player_count = cnt;
    @(posedge clk);
    model_step(r, s, ok, bad, int'(btn), int'(cnt));
    #1;
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd3);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd3);
    check("rst_view", int'(bus.view), 0);

    // Setup and grant
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 3'd3);
    check("start_view", int'(bus.view), 1);
    idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 3'd3);
    check("grant_p2", int'(bus.answerer), 2);
    check("grant_cd", int'(bus.countdown), 3);

    // Fairness: p2 wrong (saturates at 0), then 0111 -> p3, then 0111 -> p1
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 3'd3);
    check("p2_bad_sat", int'(bus.player2_score), 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 3'd3);
    check("grant_p3", int'(bus.answerer), 3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd3);
    check("p3_ok", int'(bus.player3_score), 2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 3'd3);
    check("grant_p1", int'(bus.answerer), 1);

    // Timeout of player 1 at score 0
    for (int i = 1; i <= 30; i++) begin
      idle();
      if (i == 9)  check("cd_at9", int'(bus.countdown), 3);
      if (i == 10) check("cd_at10", int'(bus.countdown), 2);
      if (i == 20) check("cd_at20", int'(bus.countdown), 1);
      if (i == 29) check("ans_at29", int'(bus.answerer), 1);
      if (i == 30) begin
        check("to_answerer", int'(bus.answerer), 0);
        check("to_score1", int'(bus.player1_score), 0);
        check("to_cd", int'(bus.countdown), 0);
        check("to_view", int'(bus.view), 1);
      end
    end

    // Win: p1 correct twice, with a double-judge cycle in between
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 3'd3);
    check("win_grant1", int'(bus.answerer), 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd3);
    check("win_s2", int'(bus.player1_score), 2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 3'd3);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 3'd3);
    check("dbl_score", int'(bus.player1_score), 2);
    check("dbl_ans", int'(bus.answerer), 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd3);
    check("win_s4", int'(bus.player1_score), 4);
    check("win_view", int'(bus.view), 2);
    check("win_who", int'(bus.winner), 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 3'd3);
    check("win_idle_view", int'(bus.view), 0);
    check("win_idle_hold", int'(bus.player1_score), 4);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 3'd3);
    check("restart_clear", int'(bus.player1_score), 0);
    check("restart_win0", int'(bus.winner), 0);

    // Masking with two players
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 3'd2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 3'd2);
    check("mask_ans", int'(bus.answerer), 0);
    check("mask_view", int'(bus.view), 1);

    // Reset during ANSWER
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 3'd2);
    check("pre_rst_ans", int'(bus.answerer), 2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd2);
    check("rst_ans", int'(bus.answerer), 0);
    check("rst_view2", int'(bus.view), 0);
    check("rst_cd", int'(bus.countdown), 0);

    // Random games
    for (int n = 0; n < 3000; n++) begin
      bit r, s, ok, bad;
      logic [3:0] btn;
      logic [2:0] cnt;
      r   = ($urandom_range(0, 599) == 0);
      s   = ($urandom_range(0, 29) == 0);
      ok  = ($urandom_range(0, 11) == 0);
      bad = ($urandom_range(0, 13) == 0);
      btn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      cnt = 3'($urandom);
      cycle(r, s, ok, bad, btn, cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game-flow controller and buzz-in arbiter for the quiz-buzzer game. Sequences the top-level view (setup, playing, win), arbitrates which player gets to answer, times the answer window and keeps all four scores. It declares the winner and drives the score/winner/view inputs of the win display and the other view blocks.

## Interface
Parameters:
- TICK_CYCLES, 100_000_000: clk cycles per countdown second
- ANSWER_SEC, 10: answer window in seconds (1..15)
- CORRECT_PTS, 2: points added on correct answer
- WRONG_PTS, 1: points deducted on wrong answer or timeout
- WIN_SCORE, 10: score at or above which the answerer wins (1..99)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  host start pulse, one cycle, debounced
- judge_ok  in  1  host "correct" pulse
- judge_bad  in  1  host "wrong" pulse
- player_btn  in  4  buzz pulses; bit i = player i+1
- player_count  in  3  number of players, sampled on start
- view  out  3  0 setup, 1 playing, 2 win
- player1_score..player4_score  out  7 each  scores 0..99
- answerer  out  3  0 none, 1..4 player holding the floor
- winner  out  3  0 none, 1..4
- countdown  out  4  seconds left in answer window, 0 outside ANSWER

## Operation
- States: IDLE (view 0), READY (view 1), ANSWER (view 1), WIN (view 2).
- IDLE: on start, clear all scores to 0, winner 0, latch player_count clamped to 2..4 (values <2 become 2, >4 become 4), set priority pointer to the last active player, and go to READY.
- READY: bits of player_btn for inactive players are masked. If any active bit is set, grant using rotating priority: search starts at pointer+1 and wraps modulo the active count. Latch the grant into answerer, move the pointer to the granted player, load countdown with ANSWER_SEC, clear the tick counter, and go to ANSWER.
- ANSWER:
  - Buzzes are ignored.
  - The tick counter counts to TICK_CYCLES-1 then wraps; on each wrap, countdown decrements.
  - judge_ok alone: score += CORRECT_PTS, saturating at 99. If the new score >= WIN_SCORE, set winner = answerer and go to WIN; otherwise go to READY.
  - judge_bad alone, or countdown reaching 0 with no judge that cycle: score -= WRONG_PTS, saturating at 0, then go to READY.
  - judge_ok and judge_bad in the same cycle: both are ignored.
  - A judge pulse in the same cycle as expiry takes precedence over the timeout.
  - On leaving ANSWER: answerer = 0 and countdown = 0.
- WIN: scores and winner are held. start returns to IDLE with scores kept. The next start from IDLE clears them.
- start is ignored in READY and ANSWER. Judge pulses are ignored outside ANSWER.

## Timing
- All outputs are registered. Reset values: view 0, all scores 0, answerer 0, winner 0, countdown 0, state IDLE, pointer 3, tick counter 0.
- Every input pulse takes effect on the next clk edge. State, view, score, answerer and winner update in the same edge.
- Buzz to answerer valid: 1 cycle.
- countdown first decrements TICK_CYCLES cycles after entering ANSWER. Timeout fires ANSWER_SEC*TICK_CYCLES cycles after entry.
- Reset mid-game returns to IDLE within 1 cycle and discards all scores.
- Score arithmetic uses 8-bit intermediates, so saturation never wraps.

## Test plan
Use TICK_CYCLES=10, ANSWER_SEC=3, CORRECT_PTS=2, WRONG_PTS=1, WIN_SCORE=4.
- Setup and grant: player_count=3, start. Then player_btn=4'b0110 → view=1, answerer=2 next cycle, countdown=3.
- Fairness: after player 2's turn resolves, press player_btn=4'b0111 → answerer=3. Press again after that turn → answerer=1.
- Masking: player_count=2, player_btn=4'b1000 → stays READY, answerer=0.
- Timeout: grant player 1 with score 0, no judge → countdown goes 3,2,1,0 at 10-cycle steps. At 30 cycles, back to READY, player1_score stays 0 (saturated).
- Win: player 1 gets judge_ok twice on separate turns → score 2, then 4. After the second, view=2 and winner=1. start → view=0 with scores held. start again → scores 0.
- Conflicts: judge_ok and judge_bad in the same cycle → no change. rst asserted during ANSWER → all outputs at reset values the next cycle.
